// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Definitions shared between the SPI write controller and the peripheral side:
// controller state encoding, frame geometry and the frame builder.
//   FRAME_W  : bits per SPI frame (R/W flag + address + data)
//   ADDR_W   : register address width
//   DATA_W   : register data width
//   RW_WRITE : value of the frame MSB that marks a write
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int unsigned FRAME_W  = 16;
   localparam int unsigned ADDR_W   = 7;
   localparam int unsigned DATA_W   = 8;
   localparam logic        RW_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_t;

   // Frame layout, MSB first on the wire: {R/W, address, data}.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] data
   );
      return {RW_WRITE, addr, data};
   endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// Half-period timer for the SPI controller. o_tick is high on the last of
// every CLK_DIV clk cycles; i_clr restarts the count so that every state
// starts a fresh, full-length half-period.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_clr   : restart the count from zero on the next edge
//   o_tick  : high during the final cycle of a half-period
// -----------------------------------------------------------------------------
module spi_tick_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

   logic [7:0] r_cnt;

   assign o_tick = (r_cnt == LP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// Single-write SPI master (mode 0, MSB first). Each accepted request becomes
// one 16-bit frame {1'b1, addr, data}: SETUP, 16 SCLK pulses, HOLD, then a GAP
// with nCS high before the next request can be taken.
//   clk       : system clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   req_valid : write request present
//   req_ready : controller idle and able to accept
//   req_addr  : 7-bit target register address (not range-checked)
//   req_data  : byte to write
//   busy      : high from accept until back in IDLE
//   done      : one-cycle pulse on the first cycle nCS is high after a frame
//   SCLK      : SPI clock, idle low
//   COPI      : serial data to the peripheral
//   nCS       : chip select, active low
// -----------------------------------------------------------------------------
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              busy,
   output logic              done,
   output logic              SCLK,
   output logic              COPI,
   output logic              nCS
);

   spi_state_t         r_state, w_state_nxt;
   logic [FRAME_W-1:0] r_frame, w_frame_nxt;
   logic [3:0]         r_bit,   w_bit_nxt;
   logic               r_sclk,  w_sclk_nxt;
   logic               r_copi,  w_copi_nxt;
   logic               r_ncs,   w_ncs_nxt;
   logic               r_done,  w_done_nxt;
   logic               r_busy,  w_busy_nxt;
   logic               r_ready, w_ready_nxt;
   logic               w_tick;
   logic               w_clr;
   logic [3:0]         w_idx;

   // Any state change restarts the half-period timer.
   assign w_clr = (w_state_nxt != r_state);

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .o_tick (w_tick)
   );

   // Frame index of the bit that follows bit r_bit (bit 0 of the count is
   // frame bit 15).
   assign w_idx = 4'd14 - r_bit;

   always_comb begin
      w_state_nxt = r_state;
      w_frame_nxt = r_frame;
      w_bit_nxt   = r_bit;
      w_sclk_nxt  = 1'b0;
      w_copi_nxt  = 1'b0;
      w_ncs_nxt   = 1'b1;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = r_busy;
      w_ready_nxt = r_ready;
      case (r_state)
         ST_IDLE: begin
            if (req_valid && r_ready) begin
               w_state_nxt = ST_SETUP;
               w_frame_nxt = build_frame(req_addr, req_data);
               w_bit_nxt   = '0;
               w_ncs_nxt   = 1'b0;
               w_copi_nxt  = w_frame_nxt[FRAME_W-1];
               w_busy_nxt  = 1'b1;
               w_ready_nxt = 1'b0;
            end
         end
         ST_SETUP: begin
            w_ncs_nxt  = 1'b0;
            w_copi_nxt = r_frame[FRAME_W-1];
            if (w_tick) begin
               w_state_nxt = ST_SHIFT;
               w_sclk_nxt  = 1'b1;
            end
         end
         ST_SHIFT: begin
            // r_sclk doubles as the phase flag: high phase vs low phase.
            w_ncs_nxt  = 1'b0;
            w_sclk_nxt = r_sclk;
            w_copi_nxt = r_copi;
            if (w_tick) begin
               if (r_sclk) begin
                  w_sclk_nxt = 1'b0;
                  if (r_bit == 4'd15) begin
                     // Last high phase done; COPI stays on bit 0 into HOLD.
                     w_state_nxt = ST_HOLD;
                  end else begin
                     w_copi_nxt = r_frame[w_idx];
                     w_bit_nxt  = r_bit + 4'd1;
                  end
               end else begin
                  w_sclk_nxt = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            w_ncs_nxt  = 1'b0;
            w_copi_nxt = r_copi;
            if (w_tick) begin
               w_state_nxt = ST_GAP;
               w_ncs_nxt   = 1'b1;
               w_copi_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
         ST_GAP: begin
            if (w_tick) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_ready_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_ready_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_frame <= '0;
         r_bit   <= '0;
         r_sclk  <= 1'b0;
         r_copi  <= 1'b0;
         r_ncs   <= 1'b1;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_frame <= w_frame_nxt;
         r_bit   <= w_bit_nxt;
         r_sclk  <= w_sclk_nxt;
         r_copi  <= w_copi_nxt;
         r_ncs   <= w_ncs_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= w_busy_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   assign req_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign SCLK      = r_sclk;
   assign COPI      = r_copi;
   assign nCS       = r_ncs;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
// Drives write requests into spi_controller and decodes the serial bus with a
// peripheral model holding registers addr0..addr4. Expected frames come from
// the requests the bench issues; expected register contents from the write
// rules (only addresses 0..4 exist in the peripheral).
// -----------------------------------------------------------------------------
module tb_spi_controller;

   localparam int unsigned CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [6:0] req_addr = '0;
   logic [7:0] req_data = '0;
   logic       busy;
   logic       done;
   logic       SCLK;
   logic       COPI;
   logic       nCS;

   spi_controller #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .busy      (busy),
      .done      (done),
      .SCLK      (SCLK),
      .COPI      (COPI),
      .nCS       (nCS)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference state
   logic [15:0] exp_q[$];
   logic [7:0]  exp_regs [0:4];

   // Peripheral model / bus monitor state
   logic [7:0]  prf [0:4];
   logic [15:0] mon_sh, mon_last;
   int unsigned mon_low, mon_rise, mon_hi, last_gap, frames_seen;
   int unsigned viol_idle, viol_stable, viol_hs, viol_done;
   logic        p_ncs, p_sclk, p_copi;

   initial begin
      for (int i = 0; i < 5; i++) begin
         prf[i]      = 8'h00;
         exp_regs[i] = 8'h00;
      end
      mon_sh = '0; mon_last = '0;
      mon_low = 0; mon_rise = 0; mon_hi = 0; last_gap = 0; frames_seen = 0;
      viol_idle = 0; viol_stable = 0; viol_hs = 0; viol_done = 0;
      p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
   end

   // Bus monitor, sampled mid-cycle.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
            mon_low = 0; mon_rise = 0; mon_hi = 0;
         end else begin
            if (req_ready == busy) viol_hs++;
            if (nCS) begin
               if (SCLK || COPI) viol_idle++;
               if (!p_ncs) begin
                  mon_last = mon_sh;
                  frames_seen++;
                  check_eq("done_at_ncs_rise", done, 1'b1);
                  check_eq("frame_expected", exp_q.size() != 0, 1'b1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check_eq("frame_bits", mon_sh, e);
                     check_eq("sclk_rises", mon_rise, 16);
                     check_eq("ncs_low_cycles", mon_low, 33 * CLK_DIV);
                     if (e[14:8] <= 7'd4) exp_regs[e[14:8]] = e[7:0];
                  end
                  if (mon_rise == 16 && mon_sh[15] && mon_sh[14:8] <= 7'd4)
                     prf[mon_sh[14:8]] = mon_sh[7:0];
                  mon_hi = 1;
               end else begin
                  mon_hi++;
                  if (done) viol_done++;
               end
            end else begin
               if (p_ncs) begin
                  last_gap = mon_hi;
                  mon_low = 0; mon_rise = 0; mon_sh = '0;
               end
               mon_low++;
               if (!busy) viol_hs++;
               if (done) viol_done++;
               if (SCLK && !p_sclk) begin
                  mon_sh = {mon_sh[14:0], COPI};
                  mon_rise++;
               end
               if (SCLK && p_sclk && (COPI != p_copi)) viol_stable++;
            end
            p_ncs = nCS; p_sclk = SCLK; p_copi = COPI;
         end
      end
   end

   // Stimulus helpers: all called just after a rising edge.
   task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      if (!req_ready) check_eq("ready_wait", req_ready, 1'b1);
   endtask

   task automatic send(input logic [6:0] a, input logic [7:0] d);
      req_addr = a; req_data = d; req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      exp_q.push_back({1'b1, a, d});
      #1 req_valid = 1'b0;
   endtask

   // Two requests with req_valid never dropped in between.
   task automatic send_pair(input logic [6:0] a1, input logic [7:0] d1,
                            input logic [6:0] a2, input logic [7:0] d2);
      req_addr = a1; req_data = d1; req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      exp_q.push_back({1'b1, a1, d1});
      #1 req_addr = a2; req_data = d2;
      wait_ready();
      @(posedge clk);
      exp_q.push_back({1'b1, a2, d2});
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || exp_q.size() != 0) && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      if (busy) check_eq("idle_wait_busy", busy, 1'b0);
      if (exp_q.size() != 0) check_eq("idle_wait_queue", exp_q.size(), 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned fs_before;
      int k;
      logic [6:0] a1, a2;
      logic [7:0] d1, d2;

      // Reset values
      #12;
      check_eq("rst_ncs", nCS, 1'b1);
      check_eq("rst_sclk", SCLK, 1'b0);
      check_eq("rst_copi", COPI, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle_cycles(3);
      check_eq("ready_after_reset", req_ready, 1'b1);

      // Single write to address 0
      send(7'h00, 8'hF0);
      check_eq("busy_after_accept", busy, 1'b1);
      check_eq("ready_after_accept", req_ready, 1'b0);
      wait_idle();
      check_eq("addr0_F0", prf[0], 8'hF0);
      check_eq("frame_80F0", mon_last, 16'h80F0);

      // Bit order on the wire
      send(7'h04, 8'hA5);
      wait_idle();
      check_eq("frame_84A5", mon_last, 16'h84A5);
      check_eq("addr4_A5", prf[4], 8'hA5);

      // Held req_valid across two requests
      send_pair(7'h01, 8'h11, 7'h02, 8'h22);
      wait_idle();
      check_eq("b2b_gap", last_gap, CLK_DIV + 1);
      check_eq("addr1_11", prf[1], 8'h11);
      check_eq("addr2_22", prf[2], 8'h22);

      // Abort mid-frame after the 7th SCLK rise
      fs_before = frames_seen;
      send(7'h03, 8'h99);
      k = 0;
      while (mon_rise < 7 && k < 400) begin
         @(posedge clk);
         k++;
      end
      check_eq("abort_reached_rise7", mon_rise >= 7, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("abort_ncs", nCS, 1'b1);
      check_eq("abort_sclk", SCLK, 1'b0);
      check_eq("abort_done", done, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      exp_q.delete();
      idle_cycles(60);
      check_eq("abort_no_frame", frames_seen - fs_before, 0);
      check_eq("abort_addr3_kept", prf[3], 8'h00);

      // Input change after accept has no effect
      send(7'h03, 8'h3C);
      idle_cycles(20);
      req_data = 8'hFF;
      req_addr = 7'h7F;
      wait_idle();
      check_eq("data_captured_3C", mon_last[7:0], 8'h3C);
      check_eq("addr3_3C", prf[3], 8'h3C);

      // Out-of-range address goes out unchanged, registers untouched
      send(7'h05, 8'h77);
      wait_idle();
      check_eq("frame_8577", mon_last, 16'h8577);
      for (int i = 0; i < 5; i++) check_eq("regs_after_addr5", prf[i], exp_regs[i]);

      // Randomised traffic
      for (int n = 0; n < 12; n++) begin
         a1 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
         a2 = 7'($urandom_range(0, 4));
         d1 = 8'($urandom);
         d2 = 8'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            send_pair(a1, d1, a2, d2);
            wait_idle();
            check_eq("rand_b2b_gap", last_gap, CLK_DIV + 1);
         end else begin
            send(a1, d1);
            wait_idle();
            check_eq("rand_frame", mon_last, {1'b1, a1, d1});
         end
         idle_cycles($urandom_range(0, 10));
      end
      idle_cycles(5);

      for (int i = 0; i < 5; i++) check_eq("final_regs", prf[i], exp_regs[i]);
      check_eq("idle_bus_violations", viol_idle, 0);
      check_eq("copi_stable_violations", viol_stable, 0);
      check_eq("ready_busy_violations", viol_hs, 0);
      check_eq("stray_done_pulses", viol_done, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter: CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  write request present.
REQ-005 SHALL have port: req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port: req_addr  input  7  target register address.
REQ-007 SHALL have port: req_data  input  8  byte to write.
REQ-008 SHALL have port: busy  output  1  high from request accept until return to IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when nCS rises at frame end.
REQ-010 SHALL have port: SCLK  output  1  SPI clock, idle low.
REQ-011 SHALL have port: COPI  output  1  serial data to peripheral.
REQ-012 SHALL have port: nCS  output  1  chip select, active-low.

Function
REQ-013 SHALL accept a request on a clk edge where req_valid and req_ready are both high; req_ready is high only in IDLE.
REQ-014 SHALL capture on accept a 16-bit frame {1'b1 (write), req_addr, req_data}, sent MSB first; later input changes have no effect.
REQ-015 SHALL not range-check req_addr; addresses above 4 are transmitted unchanged.
REQ-016 SHALL implement states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, with no other transitions.
REQ-017 SETUP: nCS low, SCLK low, COPI = frame bit 15, for CLK_DIV cycles, entered the cycle after accept.
REQ-018 SHIFT: per bit, SCLK high for CLK_DIV cycles then low for CLK_DIV cycles; COPI updates to the next bit in the same cycle SCLK falls and is stable throughout each high phase.
REQ-019 SHIFT SHALL end after the 16th high phase; a 4-bit counter tracks bits, no wrap beyond 15.
REQ-020 HOLD: nCS low, SCLK low, COPI held at bit 0, for CLK_DIV cycles.
REQ-021 GAP: nCS high, SCLK low, COPI low, for CLK_DIV cycles; done pulses on the first GAP cycle only.
REQ-022 nCS low duration SHALL be exactly 33*CLK_DIV clk cycles; exactly 16 SCLK rising edges per frame.
REQ-023 Outside SETUP..HOLD, SCLK SHALL be low, nCS high, COPI low.
REQ-024 req_valid high while not ready SHALL be ignored (no queueing); a held request is taken on the first IDLE cycle.
REQ-025 Back-to-back requests SHALL be separated by at least GAP with nCS high.
REQ-026 All outputs SHALL be registered (glitch-free SCLK, COPI, nCS).

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, nCS=1, SCLK=0, COPI=0, done=0, busy=0, counters 0, frame register 0.
REQ-028 req_ready SHALL be 1 while in reset-released IDLE.
REQ-029 Reset mid-frame SHALL abort with no done pulse; the partial frame is discarded.

Structure
REQ-030 Package spi_pkg SHALL hold the state enum, FRAME_W=16, ADDR_W=7, DATA_W=8, RW_WRITE=1'b1, shared with the peripheral.
REQ-031 One sub-module spi_tick_gen SHALL produce the CLK_DIV half-period tick, cleared on state change.

Verification
REQ-032 Reset then req_addr=7'h00, req_data=8'hF0, CLK_DIV=4 -> peripheral model captures addr0=8'hF0; nCS low 132 cycles; one done pulse.
REQ-033 Frame 7'h04/8'hA5 -> COPI sampled on 16 SCLK rising edges = 1_0000100_10100101.
REQ-034 req_valid held high for two requests (7'h01/8'h11, 7'h02/8'h22) -> two frames, nCS high >=4 cycles between, addr1=8'h11, addr2=8'h22.
REQ-035 rst_n pulsed low after 7th SCLK rise -> nCS=1, SCLK=0 same cycle, no done, peripheral registers unchanged.
REQ-036 req_data changed mid-frame from 8'h3C to 8'hFF -> transmitted byte 8'h3C.
REQ-037 Address 7'h05 with 8'h77 -> frame transmitted in full; peripheral addr0..addr4 unchanged.
